// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    // Read data returned to the owning master when the watchdog aborts a cycle.
    localparam logic [DAT_W-1:0] ABORT_DAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M1 = 2'd1,
        GNT_M2 = 2'd2
    } arb_state_t;

    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            GNT_M1:  grant_of = 2'b01;
            GNT_M2:  grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone classic bus bundle used to group one master or slave port.
interface wb_rr_arbiter_if;
    import wb_arb_pkg::*;

    // Handshake: a request is valid while cyc && stb; it completes in the cycle
    // the responder asserts ack, at which point dat_r is valid for reads.
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic [DAT_W-1:0] dat_r;
    logic             ack;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);

endinterface

// File: rtl/wb_arb_timeout.sv
// Watchdog for a stalled slave: aborts the owner's cycle after TIMEOUT
// consecutive strobed cycles without ack.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       owner_stb,
    input  logic       s_ack,
    input  logic [1:0] grant,
    output logic       abort
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_cnt;
    logic [1:0]       grant_q;
    logic             stall;

    // First cycle of a new grant counts from zero, whatever the old owner left.
    assign eff_cnt = (grant != grant_q) ? '0 : cnt;
    assign stall   = owner_stb & ~s_ack;
    assign abort   = stall & (eff_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt     <= '0;
            grant_q <= 2'b00;
        end else begin
            grant_q <= grant;
            if (s_ack || abort)
                cnt <= '0;
            else if (stall)
                cnt <= eff_cnt + 1'b1;
            else
                cnt <= eff_cnt;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with bus lock while the owner holds cyc.
// Optional stalled-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [ADR_W-1:0] m1_wishbone_adr,
    input  logic [DAT_W-1:0] m1_wishbone_dat_w,
    input  logic [SEL_W-1:0] m1_wishbone_sel,
    input  logic             m1_wishbone_we,
    input  logic             m1_wishbone_cyc,
    input  logic             m1_wishbone_stb,
    output logic [DAT_W-1:0] m1_wishbone_dat_r,
    output logic             m1_wishbone_ack,
    input  logic [ADR_W-1:0] m2_wishbone_adr,
    input  logic [DAT_W-1:0] m2_wishbone_dat_w,
    input  logic [SEL_W-1:0] m2_wishbone_sel,
    input  logic             m2_wishbone_we,
    input  logic             m2_wishbone_cyc,
    input  logic             m2_wishbone_stb,
    output logic [DAT_W-1:0] m2_wishbone_dat_r,
    output logic             m2_wishbone_ack,
    output logic [ADR_W-1:0] s_wishbone_adr,
    output logic [DAT_W-1:0] s_wishbone_dat_w,
    output logic [SEL_W-1:0] s_wishbone_sel,
    output logic             s_wishbone_we,
    output logic             s_wishbone_cyc,
    output logic             s_wishbone_stb,
    input  logic [DAT_W-1:0] s_wishbone_dat_r,
    input  logic             s_wishbone_ack,
    output logic [1:0]       grant,
    output logic             timeout
);

    arb_state_t state;
    logic       last_m2;
    logic       own_m1;
    logic       own_m2;
    logic       owner_cyc;
    logic       owner_stb;
    logic       abort;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            last_m2 <= 1'b1;
            grant   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master not served last wins.
                    if (m1_wishbone_cyc && (!m2_wishbone_cyc || last_m2)) begin
                        state   <= GNT_M1;
                        last_m2 <= 1'b0;
                        grant   <= grant_of(GNT_M1);
                    end else if (m2_wishbone_cyc) begin
                        state   <= GNT_M2;
                        last_m2 <= 1'b1;
                        grant   <= grant_of(GNT_M2);
                    end
                end
                GNT_M1: begin
                    if (!m1_wishbone_cyc) begin
                        if (m2_wishbone_cyc) begin
                            state   <= GNT_M2;
                            last_m2 <= 1'b1;
                            grant   <= grant_of(GNT_M2);
                        end else begin
                            state <= IDLE;
                            grant <= grant_of(IDLE);
                        end
                    end
                end
                GNT_M2: begin
                    if (!m2_wishbone_cyc) begin
                        if (m1_wishbone_cyc) begin
                            state   <= GNT_M1;
                            last_m2 <= 1'b0;
                            grant   <= grant_of(GNT_M1);
                        end else begin
                            state <= IDLE;
                            grant <= grant_of(IDLE);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= grant_of(IDLE);
                end
            endcase
        end
    end

    assign own_m1    = (state == GNT_M1);
    assign own_m2    = (state == GNT_M2);
    assign owner_cyc = (own_m1 & m1_wishbone_cyc) | (own_m2 & m2_wishbone_cyc);
    assign owner_stb = (own_m1 & m1_wishbone_stb) | (own_m2 & m2_wishbone_stb);

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .owner_stb (owner_stb),
        .s_ack     (s_wishbone_ack),
        .grant     (grant),
        .abort     (abort)
    );
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT > 0);
    assign abort = 1'b0;
`endif

    assign timeout = abort;

    always_comb begin
        s_wishbone_adr   = own_m2 ? m2_wishbone_adr   : m1_wishbone_adr;
        s_wishbone_dat_w = own_m2 ? m2_wishbone_dat_w : m1_wishbone_dat_w;
        s_wishbone_sel   = own_m2 ? m2_wishbone_sel   : m1_wishbone_sel;
        s_wishbone_we    = own_m2 ? m2_wishbone_we    : m1_wishbone_we;
        s_wishbone_cyc   = owner_cyc & ~abort;
        s_wishbone_stb   = owner_cyc & owner_stb & ~abort;
    end

    // Acks seen while the owner has stb low belong to no request and are dropped.
    always_comb begin
        m1_wishbone_dat_r = abort ? ABORT_DAT : s_wishbone_dat_r;
        m2_wishbone_dat_r = abort ? ABORT_DAT : s_wishbone_dat_r;
        m1_wishbone_ack   = own_m1 & m1_wishbone_stb & (s_wishbone_ack | abort);
        m2_wishbone_ack   = own_m2 & m2_wishbone_stb & (s_wishbone_ack | abort);
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, routing, round-robin, bus lock,
// reset abort and (with WB_ARB_TIMEOUT_EN) the stalled-slave watchdog.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    logic sys_clk;
    logic sys_rst;
    int   n_checks;
    int   n_errors;

    wb_rr_arbiter_if m1_bus ();
    wb_rr_arbiter_if m2_bus ();
    wb_rr_arbiter_if s_bus ();

    logic [1:0] grant;
    logic       timeout;

    wb_rr_arbiter #(
        .TIMEOUT (16)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .m1_wishbone_adr   (m1_bus.adr),
        .m1_wishbone_dat_w (m1_bus.dat_w),
        .m1_wishbone_sel   (m1_bus.sel),
        .m1_wishbone_we    (m1_bus.we),
        .m1_wishbone_cyc   (m1_bus.cyc),
        .m1_wishbone_stb   (m1_bus.stb),
        .m1_wishbone_dat_r (m1_bus.dat_r),
        .m1_wishbone_ack   (m1_bus.ack),
        .m2_wishbone_adr   (m2_bus.adr),
        .m2_wishbone_dat_w (m2_bus.dat_w),
        .m2_wishbone_sel   (m2_bus.sel),
        .m2_wishbone_we    (m2_bus.we),
        .m2_wishbone_cyc   (m2_bus.cyc),
        .m2_wishbone_stb   (m2_bus.stb),
        .m2_wishbone_dat_r (m2_bus.dat_r),
        .m2_wishbone_ack   (m2_bus.ack),
        .s_wishbone_adr    (s_bus.adr),
        .s_wishbone_dat_w  (s_bus.dat_w),
        .s_wishbone_sel    (s_bus.sel),
        .s_wishbone_we     (s_bus.we),
        .s_wishbone_cyc    (s_bus.cyc),
        .s_wishbone_stb    (s_bus.stb),
        .s_wishbone_dat_r  (s_bus.dat_r),
        .s_wishbone_ack    (s_bus.ack),
        .grant             (grant),
        .timeout           (timeout)
    );

    // Clock and reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns 1ns after the next rising edge, away from the active edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic masters_idle();
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        m2_bus.cyc = 1'b0; m2_bus.stb = 1'b0;
        s_bus.ack  = 1'b0;
    endtask

    task automatic do_reset();
        masters_idle();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        #1;
    endtask

    task automatic set_m1(input logic [29:0] adr, input logic [31:0] dat, input logic we);
        m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = 4'hF; m1_bus.we = we;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    endtask

    task automatic set_m2(input logic [29:0] adr, input logic [31:0] dat, input logic we);
        m2_bus.adr = adr; m2_bus.dat_w = dat; m2_bus.sel = 4'h3; m2_bus.we = we;
        m2_bus.cyc = 1'b1; m2_bus.stb = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_g;
        n_checks = 0;
        n_errors = 0;
        sys_rst = 1'b1;
        m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0; m1_bus.we = 1'b0;
        m2_bus.adr = '0; m2_bus.dat_w = '0; m2_bus.sel = '0; m2_bus.we = 1'b0;
        s_bus.dat_r = '0;
        masters_idle();
        #1;

        // Reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("rst_s_stb", 32'(s_bus.stb), 32'd0);
        check("rst_m1_ack", 32'(m1_bus.ack), 32'd0);
        check("rst_m2_ack", 32'(m2_bus.ack), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        tick();
        tick();
        sys_rst = 1'b0;
        #1;

        // Single m1 write routed to the slave
        set_m1(30'h10, 32'hCAFE_BABE, 1'b1);
        #1;
        check("wr_idle_grant", 32'(grant), 32'd0);
        check("wr_idle_s_cyc", 32'(s_bus.cyc), 32'd0);
        tick();
        check("wr_grant", 32'(grant), 32'd1);
        check("wr_s_adr", 32'(s_bus.adr), 32'h10);
        check("wr_s_dat", s_bus.dat_w, 32'hCAFE_BABE);
        check("wr_s_sel", 32'(s_bus.sel), 32'hF);
        check("wr_s_we", 32'(s_bus.we), 32'd1);
        check("wr_s_cyc", 32'(s_bus.cyc), 32'd1);
        check("wr_s_stb", 32'(s_bus.stb), 32'd1);
        check("wr_m1_ack_wait", 32'(m1_bus.ack), 32'd0);
        s_bus.ack = 1'b1;
        s_bus.dat_r = 32'h1234_5678;
        #1;
        check("wr_m1_ack", 32'(m1_bus.ack), 32'd1);
        check("wr_m2_ack", 32'(m2_bus.ack), 32'd0);
        check("wr_m2_dat_r_bcast", m2_bus.dat_r, 32'h1234_5678);
        tick();
        masters_idle();
        #1;
        check("wr_drop_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("wr_drop_grant", 32'(grant), 32'd1);
        tick();
        check("wr_idle_again", 32'(grant), 32'd0);

        // Simultaneous request after reset: m1 first, then direct handover
        do_reset();
        set_m1(30'h20, 32'h0, 1'b0);
        set_m2(30'h30, 32'h0, 1'b0);
        tick();
        check("tie_grant_m1", 32'(grant), 32'd1);
        check("tie_s_adr_m1", 32'(s_bus.adr), 32'h20);
        s_bus.ack = 1'b1;
        #1;
        check("tie_m1_ack", 32'(m1_bus.ack), 32'd1);
        check("tie_m2_ack", 32'(m2_bus.ack), 32'd0);
        tick();
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.ack = 1'b0;
        #1;
        check("tie_hold_m1", 32'(grant), 32'd1);
        tick();
        check("tie_grant_m2", 32'(grant), 32'd2);
        check("tie_s_adr_m2", 32'(s_bus.adr), 32'h30);
        check("tie_s_cyc_m2", 32'(s_bus.cyc), 32'd1);
        s_bus.ack = 1'b1;
        #1;
        check("tie_m2_ack_own", 32'(m2_bus.ack), 32'd1);
        check("tie_m1_ack_other", 32'(m1_bus.ack), 32'd0);
        tick();
        masters_idle();
        tick();
        check("tie_idle", 32'(grant), 32'd0);

        // Both request continuously with single-beat cycles: grants alternate
        set_m1(30'h40, 32'h0, 1'b0);
        set_m2(30'h50, 32'h0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_g));
            s_bus.ack = 1'b1;
            #1;
            check($sformatf("rr_m1_ack_%0d", k), 32'(m1_bus.ack), 32'(exp_g[0]));
            check($sformatf("rr_m2_ack_%0d", k), 32'(m2_bus.ack), 32'(exp_g[1]));
            tick();
            s_bus.ack = 1'b0;
            if (exp_g[0]) begin
                m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
            end else begin
                m2_bus.cyc = 1'b0; m2_bus.stb = 1'b0;
            end
            tick();
            if (exp_g[0]) begin
                m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
            end else begin
                m2_bus.cyc = 1'b1; m2_bus.stb = 1'b1;
            end
        end
        masters_idle();
        tick();
        check("rr_idle", 32'(grant), 32'd0);

        // Bus lock: m1 keeps cyc over 4 reads while m2 waits; stray acks dropped
        set_m1(30'h60, 32'h0, 1'b0);
        tick();
        check("lock_grant_start", 32'(grant), 32'd1);
        set_m2(30'h70, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_bus.ack = 1'b1;
            s_bus.dat_r = 32'hA0 + 32'(i);
            #1;
            check($sformatf("lock_m1_ack_%0d", i), 32'(m1_bus.ack), 32'd1);
            check($sformatf("lock_m1_dat_%0d", i), m1_bus.dat_r, 32'hA0 + 32'(i));
            check($sformatf("lock_m2_ack_%0d", i), 32'(m2_bus.ack), 32'd0);
            tick();
            check($sformatf("lock_grant_%0d", i), 32'(grant), 32'd1);
            m1_bus.stb = 1'b0;
            #1;
            check($sformatf("lock_stray_ack_%0d", i), 32'(m1_bus.ack), 32'd0);
            check($sformatf("lock_s_stb_low_%0d", i), 32'(s_bus.stb), 32'd0);
            tick();
            m1_bus.stb = 1'b1;
            s_bus.ack = 1'b0;
        end
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        #1;
        check("lock_release_hold", 32'(grant), 32'd1);
        tick();
        check("lock_handover_m2", 32'(grant), 32'd2);

        // Reset mid-read with an ack pending
        #1;
        check("mrst_s_cyc_before", 32'(s_bus.cyc), 32'd1);
        sys_rst = 1'b1;
        s_bus.ack = 1'b1;
        #1;
        check("mrst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("mrst_s_stb", 32'(s_bus.stb), 32'd0);
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_m1_ack", 32'(m1_bus.ack), 32'd0);
        check("mrst_m2_ack", 32'(m2_bus.ack), 32'd0);
        tick();
        check("mrst_m2_ack_held", 32'(m2_bus.ack), 32'd0);
        check("mrst_grant_held", 32'(grant), 32'd0);
        masters_idle();
        sys_rst = 1'b0;
        #1;

        // Slave never acks
        s_bus.dat_r = 32'h0;
        set_m1(30'h80, 32'h0, 1'b0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("to_m1_ack_%0d", c), 32'(m1_bus.ack), 32'(c == 16));
            check($sformatf("to_pulse_%0d", c), 32'(timeout), 32'(c == 16));
            check($sformatf("to_s_cyc_%0d", c), 32'(s_bus.cyc), 32'(c != 16));
            if (c == 16)
                check("to_abort_dat", m1_bus.dat_r, 32'hFFFF_FFFF);
            tick();
        end
        check("to_after_pulse", 32'(timeout), 32'd0);
        check("to_after_ack", 32'(m1_bus.ack), 32'd0);
        check("to_after_s_cyc", 32'(s_bus.cyc), 32'd1);
        check("to_after_grant", 32'(grant), 32'd1);
`else
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("stall_m1_ack_%0d", c), 32'(m1_bus.ack), 32'd0);
            check($sformatf("stall_timeout_%0d", c), 32'(timeout), 32'd0);
            check($sformatf("stall_grant_%0d", c), 32'(grant), 32'd1);
            check($sformatf("stall_s_cyc_%0d", c), 32'(s_bus.cyc), 32'd1);
            tick();
        end
`endif
        masters_idle();
        tick();
        check("final_idle", 32'(grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning cycles of stalled strobe before abort (used only with WB_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
 sys_clk  input  1  system clock, all state on rising edge
 sys_rst  input  1  asynchronous active-high reset
 m1_wishbone_adr/dat_w/sel/we/cyc/stb  input  30/32/4/1/1/1  master 1 request
 m1_wishbone_dat_r/ack  output  32/1  master 1 response
 m2_wishbone_adr/dat_w/sel/we/cyc/stb  input  30/32/4/1/1/1  master 2 request
 m2_wishbone_dat_r/ack  output  32/1  master 2 response
 s_wishbone_adr/dat_w/sel/we/cyc/stb  output  30/32/4/1/1/1  shared slave request
 s_wishbone_dat_r/ack  input  32/1  shared slave response
 grant  output  2  one-hot current owner (bit0=m1, bit1=m2), 0 when idle
 timeout  output  1  one-cycle abort pulse

Function
REQ-003 SHALL implement FSM states IDLE, GNT_M1, GNT_M2; grant is decoded from state.
REQ-004 IDLE: m1_cyc only -> GNT_M1; m2_cyc only -> GNT_M2; both -> master not last served; neither -> stay IDLE.
REQ-005 GNT_Mx: stay while mx_cyc=1; on mx_cyc=0, go directly to GNT_other if other cyc=1, else IDLE (no dead cycle on handover).
REQ-006 Grant SHALL never change while owner cyc=1 (bus lock for back-to-back/burst cycles).
REQ-007 Arbitration latency: request in IDLE at edge N appears on slave at cycle N+1 (one registered cycle).
REQ-008 Slave outputs SHALL be combinationally muxed from owner; s_cyc/s_stb SHALL be 0 in IDLE and gated by owner cyc/stb.
REQ-009 s_wishbone_dat_r SHALL be broadcast to both masters' dat_r; ack SHALL be routed only to owner, other master ack=0.
REQ-010 last-served register SHALL update on each transition into GNT_Mx.
REQ-011 Ack arriving with owner stb=0 SHALL be dropped.

Reset
REQ-012 On sys_rst=1, SHALL asynchronously enter IDLE, last-served=m2 (m1 wins first tie), grant=0, timeout=0, s_cyc=s_stb=0, both master acks=0.
REQ-013 Reset mid-transaction SHALL drop s_cyc/s_stb in the same cycle; no ack SHALL be delivered afterwards.

Configuration
REQ-014 Macro WB_ARB_TIMEOUT_EN defined: counter (clog2(TIMEOUT+1) bits) counts owner stb=1 cycles without s_ack, clears on s_ack or grant change; on reaching TIMEOUT, SHALL for one cycle assert owner ack with dat_r=32'hFFFFFFFF, force s_cyc=s_stb=0, pulse timeout=1.
REQ-015 Macro undefined: no counter; timeout tied 0; a stalled slave holds the grant indefinitely.

Structure
REQ-016 Shared package wb_arb_pkg SHALL hold FSM state typedef, widths (ADR_W=30, DAT_W=32, SEL_W=4) and abort data constant 32'hFFFFFFFF.
REQ-017 Sub-module wb_arb_timeout SHALL contain the watchdog counter, instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-018 m1 only, write adr=30'h10, dat=32'hCAFEBABE -> grant=01 next cycle, slave sees same adr/dat/sel, m1 ack on slave ack, m2 ack=0.
REQ-019 m1 and m2 cyc rise same edge after reset -> grant=01 first; m1 drops cyc -> grant=10 the next cycle, no IDLE cycle.
REQ-020 Both request continuously, single-beat cycles -> grants alternate 01,10,01,10.
REQ-021 m1 holds cyc across 4 back-to-back reads while m2 requests -> grant stays 01 until m1 cyc=0.
REQ-022 sys_rst asserted mid-read with s_ack pending -> s_cyc=0 immediately, grant=0, no ack to either master.
REQ-023 With WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> at 16th stalled cycle m1 ack=1, dat_r=32'hFFFFFFFF, timeout=1 for one cycle; without macro, stall persists and timeout stays 0.
